// File: rtl/multi_key_debounce_if.sv
// Key bus for multi_key_debounce: raw key levels in, debounced level and event pulses out.
interface multi_key_debounce_if #(
    parameter int KEY_NUM = 4
);
    logic [KEY_NUM-1:0] key_in;
    logic [KEY_NUM-1:0] key_state;
    logic [KEY_NUM-1:0] press_pulse;
    logic [KEY_NUM-1:0] release_pulse;
    logic [KEY_NUM-1:0] long_pulse;
    logic [KEY_NUM-1:0] repeat_pulse;

    modport master (
        output key_in,
        input  key_state, press_pulse, release_pulse, long_pulse, repeat_pulse
    );
    modport slave (
        input  key_in,
        output key_state, press_pulse, release_pulse, long_pulse, repeat_pulse
    );
endinterface

// File: rtl/multi_key_debounce.sv
// Per-key synchronizer, debounce FSM, long-press and (with KEY_REPEAT_EN defined) auto-repeat events.
// All outputs are registered; channels are fully independent.
module multi_key_debounce #(
    parameter int KEY_NUM    = 4,
    parameter int ACTIVE_LOW = 1,
    parameter int CNT_END    = 50_000,
    parameter int LONG_END   = 10_000_000,
    parameter int REPEAT_END = 2_500_000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multi_key_debounce_if.slave  keys
);
    localparam int HOLD_MAX = (LONG_END > REPEAT_END) ? LONG_END : REPEAT_END;
    localparam int DB_W     = $clog2(CNT_END + 1);
    localparam int HOLD_W   = $clog2(HOLD_MAX + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(CNT_END - 1);
    localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_END - 1);
`ifdef KEY_REPEAT_EN
    localparam logic [HOLD_W-1:0] REP_LAST  = HOLD_W'(REPEAT_END - 1);
`endif
    localparam logic SYNC_IDLE = (ACTIVE_LOW != 0);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRESS_DB = 3'd1,
        HELD     = 3'd2,
        LONG     = 3'd3,
        REL_DB   = 3'd4
    } state_t;

    function automatic logic [DB_W-1:0] db_inc(input logic [DB_W-1:0] v);
        return (v == {DB_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [HOLD_W-1:0] hold_inc(input logic [HOLD_W-1:0] v);
        return (v == {HOLD_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    for (genvar i = 0; i < KEY_NUM; i++) begin : g_ch
        logic              sync_p0, sync_p1;
        logic              act;
        state_t            state_q, state_d;
        logic [DB_W-1:0]   db_q, db_d;
        logic [HOLD_W-1:0] hold_q, hold_d;
        logic              from_long_q, from_long_d;
        logic              level_q, level_d;
        logic              press_q, press_d;
        logic              rel_q, rel_d;
        logic              long_q, long_d;
`ifdef KEY_REPEAT_EN
        logic              rep_q, rep_d;
`endif

        // Synchronizer resets to the released level so a held key must re-debounce after reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_p0 <= SYNC_IDLE;
                sync_p1 <= SYNC_IDLE;
            end else begin
                sync_p0 <= keys.key_in[i];
                sync_p1 <= sync_p0;
            end
        end

        assign act = sync_p1 ^ SYNC_IDLE;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q     <= IDLE;
                db_q        <= '0;
                hold_q      <= '0;
                from_long_q <= 1'b0;
                level_q     <= 1'b0;
                press_q     <= 1'b0;
                rel_q       <= 1'b0;
                long_q      <= 1'b0;
`ifdef KEY_REPEAT_EN
                rep_q       <= 1'b0;
`endif
            end else begin
                state_q     <= state_d;
                db_q        <= db_d;
                hold_q      <= hold_d;
                from_long_q <= from_long_d;
                level_q     <= level_d;
                press_q     <= press_d;
                rel_q       <= rel_d;
                long_q      <= long_d;
`ifdef KEY_REPEAT_EN
                rep_q       <= rep_d;
`endif
            end
        end

        always_comb begin
            state_d = state_q;
            unique case (state_q)
                IDLE:     if (act) state_d = PRESS_DB;
                PRESS_DB: if (!act) state_d = IDLE;
                          else if (db_q == DB_LAST) state_d = HELD;
                HELD:     if (!act) state_d = REL_DB;
                          else if (hold_q == LONG_LAST) state_d = LONG;
                LONG:     if (!act) state_d = REL_DB;
                REL_DB:   if (act) state_d = from_long_q ? LONG : HELD;
                          else if (db_q == DB_LAST) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end

        // The hold counter is left untouched in REL_DB so a bounce only pauses the hold time.
        always_comb begin
            db_d        = db_q;
            hold_d      = hold_q;
            from_long_d = from_long_q;
            level_d     = level_q;
            press_d     = 1'b0;
            rel_d       = 1'b0;
            long_d      = 1'b0;
`ifdef KEY_REPEAT_EN
            rep_d       = 1'b0;
`endif
            unique case (state_q)
                IDLE: db_d = '0;
                PRESS_DB: begin
                    if (act) begin
                        if (db_q == DB_LAST) begin
                            press_d = 1'b1;
                            level_d = 1'b1;
                            hold_d  = '0;
                        end else begin
                            db_d = db_inc(db_q);
                        end
                    end
                end
                HELD: begin
                    if (!act) begin
                        db_d        = '0;
                        from_long_d = 1'b0;
                    end else if (hold_q == LONG_LAST) begin
                        long_d = 1'b1;
                        hold_d = '0;
                    end else begin
                        hold_d = hold_inc(hold_q);
                    end
                end
                LONG: begin
                    if (!act) begin
                        db_d        = '0;
                        from_long_d = 1'b1;
                    end
`ifdef KEY_REPEAT_EN
                    else if (hold_q == REP_LAST) begin
                        rep_d  = 1'b1;
                        hold_d = '0;
                    end else begin
                        hold_d = hold_inc(hold_q);
                    end
`endif
                end
                REL_DB: begin
                    if (!act) begin
                        if (db_q == DB_LAST) begin
                            rel_d   = 1'b1;
                            level_d = 1'b0;
                        end else begin
                            db_d = db_inc(db_q);
                        end
                    end
                end
                default: ;
            endcase
        end

        assign keys.key_state[i]     = level_q;
        assign keys.press_pulse[i]   = press_q;
        assign keys.release_pulse[i] = rel_q;
        assign keys.long_pulse[i]    = long_q;
`ifdef KEY_REPEAT_EN
        assign keys.repeat_pulse[i]  = rep_q;
`else
        assign keys.repeat_pulse[i]  = 1'b0;
`endif
    end
endmodule

// File: tb/tb_multi_key_debounce.sv
// Bench for multi_key_debounce: vector table, directed corner sequences and random keys vs a run-length model.
module tb_multi_key_debounce;
    localparam int N          = 4;
    localparam int CNT_END    = 8;
    localparam int LONG_END   = 32;
    localparam int REPEAT_END = 16;
`ifdef KEY_REPEAT_EN
    localparam bit REPEAT_ON = 1'b1;
`else
    localparam bit REPEAT_ON = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    multi_key_debounce_if #(.KEY_NUM(N)) kb ();

    multi_key_debounce #(
        .KEY_NUM(N), .ACTIVE_LOW(1), .CNT_END(CNT_END),
        .LONG_END(LONG_END), .REPEAT_END(REPEAT_END)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .keys(kb)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: two-cycle input delay, then run lengths of the active level.
    logic [N-1:0] m_s0, m_s1;
    logic [N-1:0] m_pr, m_press, m_rel, m_long, m_rep, m_prev, m_ldone;
    int m_streak[N];
    int m_hold[N];
    int m_rcnt[N];

    int w_first[4];
    int w_cnt[4];

    typedef struct {
        logic [3:0] key;
        int         cycles;
        logic [3:0] state;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] lng;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_s0 = '1; m_s1 = '1;
        m_pr = '0; m_press = '0; m_rel = '0; m_long = '0; m_rep = '0; m_prev = '0; m_ldone = '0;
        for (int ch = 0; ch < N; ch++) begin
            m_streak[ch] = 0; m_hold[ch] = 0; m_rcnt[ch] = 0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] key);
        bit a;
        for (int ch = 0; ch < N; ch++) begin
            a = ~m_s1[ch];
            m_press[ch] = 1'b0; m_rel[ch] = 1'b0; m_long[ch] = 1'b0; m_rep[ch] = 1'b0;
            if (!m_pr[ch]) begin
                m_streak[ch] = a ? m_streak[ch] + 1 : 0;
                if (m_streak[ch] == CNT_END + 1) begin
                    m_pr[ch] = 1'b1; m_press[ch] = 1'b1; m_streak[ch] = 0;
                    m_hold[ch] = 0; m_rcnt[ch] = 0; m_ldone[ch] = 1'b0;
                end
            end else begin
                // Hold time only advances on cycles where the key stayed active.
                if (a && m_prev[ch]) begin
                    if (!m_ldone[ch]) begin
                        m_hold[ch]++;
                        if (m_hold[ch] == LONG_END) begin
                            m_long[ch] = 1'b1; m_ldone[ch] = 1'b1;
                        end
                    end else if (REPEAT_ON) begin
                        m_rcnt[ch]++;
                        if (m_rcnt[ch] == REPEAT_END) begin
                            m_rep[ch] = 1'b1; m_rcnt[ch] = 0;
                        end
                    end
                end
                m_streak[ch] = a ? 0 : m_streak[ch] + 1;
                if (m_streak[ch] == CNT_END + 1) begin
                    m_pr[ch] = 1'b0; m_rel[ch] = 1'b1; m_streak[ch] = 0;
                end
            end
            m_prev[ch] = a;
        end
        m_s1 = m_s0;
        m_s0 = key;
    endtask

    task automatic step();
        @(posedge clk);
        model_step(kb.key_in);
        #1;
        chk("model", {12'h0, kb.key_state, kb.press_pulse, kb.release_pulse, kb.long_pulse, kb.repeat_pulse},
                     {12'h0, m_pr, m_press, m_rel, m_long, m_rep});
    endtask

    task automatic watch(input int n, input int ch);
        logic [3:0] ev;
        for (int k = 0; k < 4; k++) begin
            w_first[k] = -1; w_cnt[k] = 0;
        end
        for (int j = 1; j <= n; j++) begin
            step();
            ev = {kb.repeat_pulse[ch], kb.long_pulse[ch], kb.release_pulse[ch], kb.press_pulse[ch]};
            for (int k = 0; k < 4; k++) begin
                if (ev[k]) begin
                    if (w_first[k] < 0) w_first[k] = j;
                    w_cnt[k]++;
                end
            end
        end
    endtask

    task automatic do_reset(input string name);
        rst_n = 1'b0;
        #1;
        chk(name, {12'h0, kb.key_state, kb.press_pulse, kb.release_pulse, kb.long_pulse, kb.repeat_pulse}, 32'h0);
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int remain[N];
        logic [N-1:0] lvl;

        tbl[0]  = '{4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{4'hE, 10, 4'h0, 4'h0, 4'h0, 4'h0};
        tbl[2]  = '{4'hE,  1, 4'h1, 4'h1, 4'h0, 4'h0};
        tbl[3]  = '{4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[4]  = '{4'hC,  5, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[5]  = '{4'hE, 12, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[6]  = '{4'hE, 13, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[7]  = '{4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h1};
        tbl[8]  = '{4'hE,  1, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[9]  = '{4'hF, 10, 4'h1, 4'h0, 4'h0, 4'h0};
        tbl[10] = '{4'hF,  1, 4'h0, 4'h0, 4'h1, 4'h0};
        tbl[11] = '{4'hF,  1, 4'h0, 4'h0, 4'h0, 4'h0};

        kb.key_in = '1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {12'h0, kb.key_state, kb.press_pulse, kb.release_pulse, kb.long_pulse, kb.repeat_pulse}, 32'h0);
        rst_n = 1'b1;

        // Key 0 press/long/release with a 5-cycle glitch on key 1.
        for (int r = 0; r < 12; r++) begin
            kb.key_in = tbl[r].key;
            repeat (tbl[r].cycles) step();
            chk($sformatf("table_row%0d", r),
                {16'h0, kb.key_state, kb.press_pulse, kb.release_pulse, kb.long_pulse},
                {16'h0, tbl[r].state, tbl[r].press, tbl[r].rel, tbl[r].lng});
        end

        // Key 2 held 60 cycles: press, long, then auto-repeat when enabled.
        kb.key_in = 4'b1011;
        watch(60, 2);
        chk("hold_press_cycle", w_first[0], 11);
        chk("hold_long_cycle", w_first[2], 11 + LONG_END);
        chk("hold_long_count", w_cnt[2], 1);
        chk("hold_rep_count", w_cnt[3], REPEAT_ON ? 1 : 0);
        chk("hold_rep_cycle", w_first[3], REPEAT_ON ? 11 + LONG_END + REPEAT_END : -1);
        kb.key_in = 4'hF;
        watch(12, 2);
        chk("hold_release_cycle", w_first[1], CNT_END + 3);

        // Key 1: a 4-cycle bounce during HELD freezes the hold count for 5 cycles.
        kb.key_in = 4'b1101;
        watch(11, 1);
        chk("bounce_press_cycle", w_first[0], 11);
        watch(5, 1);
        kb.key_in = 4'hF;
        watch(4, 1);
        chk("bounce_no_release_a", w_cnt[1], 0);
        kb.key_in = 4'b1101;
        watch(40, 1);
        chk("bounce_long_cycle", w_first[2], 28);
        chk("bounce_no_release_b", w_cnt[1], 0);
        chk("bounce_no_press", w_cnt[0], 0);
        kb.key_in = 4'hF;
        watch(12, 1);
        chk("bounce_release_cycle", w_first[1], CNT_END + 3);

        // All four keys pressed and released together.
        kb.key_in = 4'h0;
        for (int j = 1; j <= 11; j++) begin
            step();
            if (j == 10) chk("all_press_early", kb.press_pulse, 4'h0);
        end
        chk("all_press", kb.press_pulse, 4'hF);
        chk("all_state", kb.key_state, 4'hF);
        repeat (5) step();
        kb.key_in = 4'hF;
        for (int j = 1; j <= 11; j++) begin
            step();
            if (j == 10) chk("all_release_early", kb.release_pulse, 4'h0);
        end
        chk("all_release", kb.release_pulse, 4'hF);
        chk("all_state_off", kb.key_state, 4'h0);
        step();

        // Reset while key 3 is in HELD: outputs clear at once and the press is re-debounced.
        kb.key_in = 4'b0111;
        watch(16, 3);
        chk("rst_first_press", w_first[0], 11);
        do_reset("rst_mid_held");
        watch(15, 3);
        chk("rst_repress_cycle", w_first[0], CNT_END + 3);
        chk("rst_no_release", w_cnt[1], 0);
        chk("rst_state", kb.key_state, 4'b1000);
        kb.key_in = 4'hF;
        watch(12, 3);
        chk("rst_release_cycle", w_first[1], CNT_END + 3);

        // Random per-key run lengths: short bounces mixed with long holds.
        lvl = '1;
        for (int ch = 0; ch < N; ch++) remain[ch] = 1;
        for (int t = 0; t < 3000; t++) begin
            for (int ch = 0; ch < N; ch++) begin
                remain[ch]--;
                if (remain[ch] <= 0) begin
                    lvl[ch] = ~lvl[ch];
                    remain[ch] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6))
                                                              : int'($urandom_range(8, 70));
                end
            end
            kb.key_in = lvl;
            if (t == 1500) do_reset("rst_random");
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
